// File: rtl/fifo_burst_rd_ctrl.sv
// Burst read controller: drains an FWFT FIFO in fixed or flushed partial bursts,
// issuing a command (addr/len) per burst and streaming the beats out with last/done.
//
// state | meaning
// IDLE  | wait for a full burst worth of words, or flush with a non-empty FIFO
// REQ   | burst command presented, held until burst_ack
// DATA  | beats streamed straight from the FIFO head, one pop per accepted beat
// DONE  | one-cycle done pulse; start address advances and wraps inside the region
module fifo_burst_rd_ctrl #(
   parameter int                    RD_WIDTH     = 32,
   parameter int                    RD_CNT_WIDTH = 11,
   parameter int                    BURST_LEN    = 16,
   parameter int                    ADDR_WIDTH   = 30,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    ADDR_SPAN    = 4096
) (
   input  logic                    rd_clk,
   input  logic                    rd_rst_n,
   input  logic                    fifo_empty,
   input  logic [RD_CNT_WIDTH-1:0] rd_data_count,
   input  logic [RD_WIDTH-1:0]     rd_data,
   output logic                    fifo_rd_en,
   input  logic                    flush,
   output logic                    burst_req,
   input  logic                    burst_ack,
   output logic [ADDR_WIDTH-1:0]   burst_addr,
   output logic [7:0]              burst_len,
   output logic                    burst_valid,
   input  logic                    burst_ready,
   output logic [RD_WIDTH-1:0]     burst_data,
   output logic                    burst_last,
   output logic                    burst_done
);

   localparam int BEAT_W = $clog2(BURST_LEN) + 1;
   localparam int BYTES  = RD_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] ADDR_END  = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(ADDR_SPAN);
   localparam logic [BEAT_W-1:0]   FULL_BEATS = BEAT_W'(BURST_LEN);
   localparam logic [7:0]          FULL_LEN   = 8'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

   state_t                state_q, state_d;
   logic [BEAT_W-1:0]     beats_q, beats_d;
   logic [BEAT_W-1:0]     remaining_q, remaining_d;
   logic [7:0]            len_q, len_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   addr_adv;
   logic [ADDR_WIDTH:0]   addr_next;

   // One extra bit so the advanced address can be compared against the region end.
   always_comb begin
      addr_adv  = {1'b0, addr_q} + ((ADDR_WIDTH+1)'(beats_q) * (ADDR_WIDTH+1)'(BYTES));
      addr_next = addr_adv;
      if (addr_adv >= ADDR_END) begin
         addr_next = addr_adv - (ADDR_WIDTH+1)'(ADDR_SPAN);
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q     <= IDLE;
         beats_q     <= '0;
         remaining_q <= '0;
         len_q       <= '0;
         addr_q      <= BASE_ADDR;
      end else begin
         state_q     <= state_d;
         beats_q     <= beats_d;
         remaining_q <= remaining_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      beats_d     = beats_q;
      remaining_d = remaining_q;
      len_d       = len_q;
      addr_d      = addr_q;

      burst_req   = 1'b0;
      burst_valid = 1'b0;
      burst_last  = 1'b0;
      burst_done  = 1'b0;
      fifo_rd_en  = 1'b0;

      case (state_q)
         IDLE: begin
            if (rd_data_count >= RD_CNT_WIDTH'(BURST_LEN)) begin
               beats_d     = FULL_BEATS;
               remaining_d = FULL_BEATS;
               len_d       = FULL_LEN;
               state_d     = REQ;
            end else if (flush && !fifo_empty && (rd_data_count != '0)) begin
               beats_d     = BEAT_W'(rd_data_count);
               remaining_d = BEAT_W'(rd_data_count);
               len_d       = 8'(rd_data_count - RD_CNT_WIDTH'(1));
               state_d     = REQ;
            end
         end
         REQ: begin
            burst_req = 1'b1;
            if (burst_ack) begin
               state_d = DATA;
            end
         end
         DATA: begin
            // An empty head mid-burst is a protocol error: present no beat at all.
            burst_valid = (remaining_q != '0) && !fifo_empty;
            burst_last  = burst_valid && (remaining_q == BEAT_W'(1));
            fifo_rd_en  = burst_valid && burst_ready;
            if (fifo_rd_en) begin
               remaining_d = remaining_q - BEAT_W'(1);
            end
            if (burst_last && burst_ready) begin
               state_d = DONE;
            end
         end
         DONE: begin
            burst_done = 1'b1;
            addr_d     = addr_next[ADDR_WIDTH-1:0];
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign burst_data = rd_data;
   assign burst_len  = len_q;
   assign burst_addr = addr_q;

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Bench for fifo_burst_rd_ctrl: FWFT FIFO modelled as a queue, transaction-level
// scoreboard for commands, beats, done pulses and wrapped start addresses.
module tb_fifo_burst_rd_ctrl;

   localparam int RD_WIDTH     = 32;
   localparam int RD_CNT_WIDTH = 11;
   localparam int BURST_LEN    = 16;
   localparam int ADDR_WIDTH   = 30;
   localparam int BASE         = 0;
   localparam int SPAN         = 128;
   localparam int BYTES        = RD_WIDTH / 8;

   logic                    rd_clk = 1'b0;
   logic                    rd_rst_n = 1'b0;
   logic                    fifo_empty;
   logic [RD_CNT_WIDTH-1:0] rd_data_count;
   logic [RD_WIDTH-1:0]     rd_data;
   logic                    fifo_rd_en;
   logic                    flush = 1'b0;
   logic                    burst_req;
   logic                    burst_ack;
   logic [ADDR_WIDTH-1:0]   burst_addr;
   logic [7:0]              burst_len;
   logic                    burst_valid;
   logic                    burst_ready;
   logic [RD_WIDTH-1:0]     burst_data;
   logic                    burst_last;
   logic                    burst_done;

   always #5 rd_clk = ~rd_clk;

   fifo_burst_rd_ctrl #(
      .RD_WIDTH     (RD_WIDTH),
      .RD_CNT_WIDTH (RD_CNT_WIDTH),
      .BURST_LEN    (BURST_LEN),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .BASE_ADDR    (ADDR_WIDTH'(BASE)),
      .ADDR_SPAN    (SPAN)
   ) dut (
      .rd_clk        (rd_clk),
      .rd_rst_n      (rd_rst_n),
      .fifo_empty    (fifo_empty),
      .rd_data_count (rd_data_count),
      .rd_data       (rd_data),
      .fifo_rd_en    (fifo_rd_en),
      .flush         (flush),
      .burst_req     (burst_req),
      .burst_ack     (burst_ack),
      .burst_addr    (burst_addr),
      .burst_len     (burst_len),
      .burst_valid   (burst_valid),
      .burst_ready   (burst_ready),
      .burst_data    (burst_data),
      .burst_last    (burst_last),
      .burst_done    (burst_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [RD_WIDTH-1:0] fifo_q[$];

   // Reference model: what the burst protocol promises, tracked per transaction.
   bit     req_open, data_open, done_due, prev_valid, prev_flush, prev_empty;
   bit     hide, rand_mode;
   int     prev_count, exp_beats, beats_seen, since_done, cyc, done_cnt;
   int     ack_block, ready_mode, ack_mode, first_pop, cur_req_cycles;
   longint exp_addr;
   int     req_cycle_q[$], req_addr_q[$], req_len_q[$], req_dur_q[$];
   int     done_cycle_q[$], pop_span_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req"},   burst_req,   1'b0);
      chk({tag, "_valid"}, burst_valid, 1'b0);
      chk({tag, "_last"},  burst_last,  1'b0);
      chk({tag, "_done"},  burst_done,  1'b0);
      chk({tag, "_rden"},  fifo_rd_en,  1'b0);
      chk({tag, "_len"},   burst_len,   8'd0);
      chk({tag, "_addr"},  burst_addr,  ADDR_WIDTH'(BASE));
   endtask

   task automatic model_reset();
      req_open   = 0;
      data_open  = 0;
      done_due   = 0;
      prev_valid = 0;
      since_done = 100;
      exp_addr   = BASE;
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back($urandom);
   endtask

   task automatic drive_inputs();
      hide          = rand_mode && data_open && ($urandom_range(7) == 0);
      fifo_empty    = hide || (fifo_q.size() == 0);
      rd_data_count = hide ? '0 : RD_CNT_WIDTH'(fifo_q.size());
      rd_data       = (fifo_q.size() != 0) ? fifo_q[0] : '0;
      case (ready_mode)
         0:       burst_ready = 1'b1;
         1:       burst_ready = (cyc % 2 == 0);
         default: burst_ready = 1'($urandom_range(1));
      endcase
      case (ack_mode)
         0:       burst_ack = 1'b1;
         1:       burst_ack = (ack_block == 0);
         default: burst_ack = 1'($urandom_range(1));
      endcase
   endtask

   task automatic cycle();
      bit pop, go_data, exp_req, exp_valid;
      drive_inputs();
      @(negedge rd_clk);
      go_data = 0;
      if (!rd_rst_n) begin
         check_reset("rst_hold");
         prev_valid = 0;
      end else begin
         if (since_done < 100) since_done++;
         if (done_due) begin
            chk("done_pulse", burst_done,  1'b1);
            chk("done_req",   burst_req,   1'b0);
            chk("done_valid", burst_valid, 1'b0);
            chk("done_rden",  fifo_rd_en,  1'b0);
            exp_addr += longint'(exp_beats) * BYTES;
            if (exp_addr >= BASE + SPAN) exp_addr = BASE + (exp_addr - (BASE + SPAN));
            done_due   = 0;
            since_done = 0;
            done_cnt++;
            done_cycle_q.push_back(cyc);
         end else begin
            chk("done_quiet", burst_done, 1'b0);
            if (!req_open && !data_open) begin
               exp_req = prev_valid && (since_done >= 2) &&
                         ((prev_count >= BURST_LEN) || (prev_flush && !prev_empty));
               chk("req_start", burst_req, exp_req);
               if (burst_req) begin
                  req_open       = 1;
                  cur_req_cycles = 0;
                  exp_beats      = (prev_count >= BURST_LEN) ? BURST_LEN : prev_count;
                  req_cycle_q.push_back(cyc);
                  req_addr_q.push_back(int'(burst_addr));
                  req_len_q.push_back(int'(burst_len));
               end else begin
                  chk("idle_valid", burst_valid, 1'b0);
                  chk("idle_rden",  fifo_rd_en,  1'b0);
               end
            end
            if (req_open) begin
               cur_req_cycles++;
               chk("req_held",  burst_req,   1'b1);
               chk("req_addr",  burst_addr,  ADDR_WIDTH'(exp_addr));
               chk("req_len",   burst_len,   8'(exp_beats - 1));
               chk("req_valid", burst_valid, 1'b0);
               chk("req_rden",  fifo_rd_en,  1'b0);
               if (burst_ack) begin
                  go_data = 1;
                  req_dur_q.push_back(cur_req_cycles);
               end
               if (!burst_ack && ack_block > 0) ack_block--;
            end else if (data_open) begin
               exp_valid = !fifo_empty;
               chk("data_req",   burst_req,   1'b0);
               chk("data_valid", burst_valid, exp_valid);
               chk("data_rden",  fifo_rd_en,  exp_valid && burst_ready);
               if (exp_valid) begin
                  chk("data_word", burst_data, fifo_q[0]);
                  chk("data_last", burst_last, beats_seen == exp_beats - 1);
               end else begin
                  chk("data_last_empty", burst_last, 1'b0);
               end
            end
         end
         prev_valid = 1;
         prev_count = int'(rd_data_count);
         prev_flush = flush;
         prev_empty = fifo_empty;
      end
      pop = rd_rst_n && fifo_rd_en;
      @(posedge rd_clk);
      #1;
      if (go_data) begin
         req_open   = 0;
         data_open  = 1;
         beats_seen = 0;
      end
      if (pop) begin
         if (fifo_q.size() != 0) void'(fifo_q.pop_front());
         if (data_open) begin
            if (beats_seen == 0) first_pop = cyc;
            beats_seen++;
            if (beats_seen == exp_beats) begin
               data_open = 0;
               done_due  = 1;
               pop_span_q.push_back(cyc - first_pop);
            end
         end
      end
      cyc++;
   endtask

   task automatic run_bursts(input int n, input int max_cyc);
      int target;
      target = done_cnt + n;
      for (int i = 0; i < max_cyc && done_cnt < target; i++) cycle();
      chk("burst_timeout", done_cnt, target);
   endtask

   initial begin
      int rel_cyc, nd, nr;
      model_reset();
      cyc = 0; done_cnt = 0; ack_block = 0;
      ready_mode = 0; ack_mode = 0; rand_mode = 0;
      #1;
      check_reset("rst_init");
      for (int i = 0; i < 3; i++) cycle();

      // Full burst, ack and ready always high; first request one cycle after release.
      push(16);
      rd_rst_n = 1'b1;
      rel_cyc  = cyc;
      run_bursts(1, 60);
      chk("first_req_cycle", req_cycle_q[0], rel_cyc + 1);
      chk("full_len",        req_len_q[0],   15);
      chk("full_addr",       req_addr_q[0],  0);
      chk("full_pop_span",   pop_span_q[0],  15);
      chk("full_next_addr",  burst_addr,     ADDR_WIDTH'(64));

      // Flushed partial burst of five words.
      flush = 1'b1;
      push(5);
      run_bursts(1, 40);
      flush = 1'b0;
      chk("flush_len",       req_len_q[$],   4);
      chk("flush_next_addr", burst_addr,     ADDR_WIDTH'(84));

      // Ack withheld for ten request cycles; address wraps past the region end.
      ack_mode  = 1;
      ack_block = 10;
      push(16);
      run_bursts(1, 80);
      ack_mode = 0;
      chk("ack_wait_cycles", req_dur_q[$],  11);
      chk("wrap_next_addr",  burst_addr,    ADDR_WIDTH'(20));

      // Forty words with ready toggling: two back-to-back bursts, then a flushed tail.
      ready_mode = 1;
      push(40);
      run_bursts(2, 160);
      nd = done_cycle_q.size();
      nr = req_cycle_q.size();
      chk("b2b_gap",     req_cycle_q[nr-1] - done_cycle_q[nd-2], 2);
      chk("b2b_len",     req_len_q[nr-1],  15);
      chk("b2b_fifo",    fifo_q.size(),    8);
      chk("b2b_addr",    burst_addr,       ADDR_WIDTH'(20));
      flush = 1'b1;
      run_bursts(1, 60);
      flush = 1'b0;
      ready_mode = 0;
      chk("tail_len",  req_len_q[$], 7);
      chk("tail_addr", burst_addr,   ADDR_WIDTH'(52));

      // Fresh start from reset, three full bursts in a 128-byte region.
      rd_rst_n = 1'b0;
      #1;
      check_reset("rst_wrap");
      model_reset();
      for (int i = 0; i < 2; i++) cycle();
      push(48);
      rd_rst_n = 1'b1;
      run_bursts(3, 200);
      nr = req_addr_q.size();
      chk("wrap_addr0", req_addr_q[nr-3], 0);
      chk("wrap_addr1", req_addr_q[nr-2], 64);
      chk("wrap_addr2", req_addr_q[nr-1], 0);

      // Reset asserted after seven beats of a burst.
      push(16);
      for (int i = 0; i < 60 && !(data_open && beats_seen == 7); i++) cycle();
      chk("mid_beats", beats_seen, 7);
      rd_rst_n = 1'b0;
      #1;
      check_reset("rst_mid");
      model_reset();
      for (int i = 0; i < 2; i++) cycle();
      chk("mid_fifo_left", fifo_q.size(), 9);
      push(7);
      rd_rst_n = 1'b1;
      rel_cyc  = cyc;
      run_bursts(1, 60);
      chk("mid_restart_cycle", req_cycle_q[$], rel_cyc + 1);
      chk("mid_restart_addr",  req_addr_q[$],  BASE);

      // Randomized traffic, handshakes and flush, with occasional empty head mid-burst.
      rand_mode  = 1;
      ready_mode = 2;
      ack_mode   = 2;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(3) == 0 && fifo_q.size() < 150) push($urandom_range(6));
         if ($urandom_range(15) == 0) flush = ~flush;
         cycle();
      end

      // Drain everything left.
      rand_mode  = 0;
      ready_mode = 0;
      ack_mode   = 0;
      flush      = 1'b1;
      for (int i = 0; i < 600 && (fifo_q.size() != 0 || req_open || data_open || done_due); i++) cycle();
      for (int i = 0; i < 3; i++) cycle();
      chk("drain_fifo", fifo_q.size(), 0);
      chk("drain_idle", burst_req,     1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_burst_rd_ctrl.md
FIFO_BURST_RD_CTRL -- requirements
Module: fifo_burst_rd_ctrl

Interface
REQ-001 Parameter RD_WIDTH, 32, FIFO read-port data width in bits.
REQ-002 Parameter RD_CNT_WIDTH, 11, width of the FIFO read-side data count.
REQ-003 Parameter BURST_LEN, 16, beats per full burst; power of two, at least 2.
REQ-004 Parameter ADDR_WIDTH, 30, byte-address width.
REQ-005 Parameter BASE_ADDR, 0, first burst address; RD_WIDTH/8-aligned.
REQ-006 Parameter ADDR_SPAN, 4096, byte size of the circular target region; multiple of BURST_LEN*RD_WIDTH/8.
REQ-007 rd_clk  in  1  sole clock; all logic on rising edge.
REQ-008 rd_rst_n  in  1  asynchronous, active-low reset.
REQ-009 fifo_empty  in  1  FIFO empty flag (FWFT FIFO).
REQ-010 rd_data_count  in  RD_CNT_WIDTH  FIFO read-side word count.
REQ-011 rd_data  in  RD_WIDTH  FIFO head word, valid whenever fifo_empty=0.
REQ-012 fifo_rd_en  out  1  FIFO pop strobe.
REQ-013 flush  in  1  level; drain a partial burst when the FIFO holds fewer than BURST_LEN words.
REQ-014 burst_req  out  1  burst command valid.
REQ-015 burst_ack  in  1  burst command accepted.
REQ-016 burst_addr  out  ADDR_WIDTH  burst start byte address.
REQ-017 burst_len  out  8  beats minus one.
REQ-018 burst_valid  out  1  data beat valid.
REQ-019 burst_ready  in  1  data beat accepted.
REQ-020 burst_data  out  RD_WIDTH  data beat; combinationally equal to rd_data.
REQ-021 burst_last  out  1  marks the final beat of a burst.
REQ-022 burst_done  out  1  one-cycle pulse after the final beat transfers.

Function
REQ-023 FSM states: IDLE, REQ, DATA, DONE.
REQ-024 IDLE->REQ when rd_data_count>=BURST_LEN; latch beats=BURST_LEN.
REQ-025 IDLE->REQ when rd_data_count<BURST_LEN, flush=1 and fifo_empty=0; latch beats=rd_data_count, which is non-zero.
REQ-026 The beat count is latched at the IDLE->REQ edge and does not change for the rest of the burst.
REQ-027 REQ: burst_req=1, burst_len=beats-1 and burst_addr stay held until the cycle in which burst_ack=1; then move to DATA.
REQ-028 DATA: burst_valid=1 while remaining beats>0.
REQ-029 DATA: fifo_rd_en=burst_valid&burst_ready; no other state asserts fifo_rd_en.
REQ-030 DATA: remaining beats decrement on each fifo_rd_en.
REQ-031 burst_last=1 when burst_valid=1 and remaining=1.
REQ-032 DATA->DONE on the beat where burst_last&burst_ready.
REQ-033 DONE: burst_done=1 for exactly one cycle.
REQ-034 DONE: burst_addr advances by beats*RD_WIDTH/8.
REQ-035 DONE: if the advanced address is >=BASE_ADDR+ADDR_SPAN, it becomes BASE_ADDR+(advanced-(BASE_ADDR+ADDR_SPAN)).
REQ-036 DONE->IDLE unconditionally; minimum spacing between burst_req assertions is 1 IDLE cycle.
REQ-037 Beat latency: data is combinational from the FWFT head; zero-cycle burst_data path; pop takes effect at the accepting edge.
REQ-038 A burst starts only with enough words; if fifo_empty=1 in DATA (protocol error), burst_valid is forced to 0 and fifo_rd_en to 0.
REQ-039 burst_ready=0 stalls without popping, holding burst_data and burst_last.
REQ-040 A flush deassert during REQ or DATA has no effect on the committed burst.
REQ-041 Only burst_ack in REQ and burst_ready in DATA are honoured; both are ignored in other states.

Reset
REQ-042 Asynchronous assertion forces IDLE and abandons any burst in progress.
REQ-043 During reset: burst_req=0, burst_valid=0, burst_last=0, burst_done=0, fifo_rd_en=0, burst_len=0, burst_addr=BASE_ADDR, remaining=0.
REQ-044 Release is sampled on the rising edge of rd_clk; the first possible burst_req is one cycle after release.

Verification
REQ-045 Count=16, ack same cycle, ready always 1 -> burst_len=15, addr=0, 16 pops on consecutive cycles, last on beat 16, done pulse, next addr=64.
REQ-046 Count=5, flush=1 -> burst_len=4, 5 beats, next addr advances by 20.
REQ-047 Count=40, ready toggles 1/0 -> exactly 16 pops per burst, data unchanged while stalled, two bursts back to back with 1 IDLE cycle between.
REQ-048 ADDR_SPAN=128, three full bursts -> addresses 0, 64, 0.
REQ-049 Reset asserted mid-DATA after 7 beats -> all outputs at reset values immediately; after release with count>=16, a new burst starts at BASE_ADDR.
REQ-050 burst_ack held 0 for 10 cycles -> burst_req, addr and len held stable, no pops, then normal burst.
